seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_pattern_decode.sv | 30 +++
 rtl/seg_scan_decoder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns, special codes, FSM states and display encoder table
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Patterns are seg[7:1] = {A,B,C,D,E,F,G}; DP is never part of a pattern.
  localparam logic [6:0] PAT_0     = 7'b1111110;
  localparam logic [6:0] PAT_1     = 7'b0110000;
  localparam logic [6:0] PAT_2     = 7'b1101101;
  localparam logic [6:0] PAT_3     = 7'b1111001;
  localparam logic [6:0] PAT_4     = 7'b0110011;
  localparam logic [6:0] PAT_5     = 7'b1011011;
  localparam logic [6:0] PAT_6     = 7'b1011111;
  localparam logic [6:0] PAT_7     = 7'b1110000;
  localparam logic [6:0] PAT_8     = 7'b1111111;
  localparam logic [6:0] PAT_9     = 7'b1110011;
  localparam logic [6:0] PAT_MINUS = 7'b0000001;
  localparam logic [6:0] PAT_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Display encoder table: inverse of the decoder, unknown codes show blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    case (code)
      4'h0:       return PAT_0;
      4'h1:       return PAT_1;
      4'h2:       return PAT_2;
      4'h3:       return PAT_3;
      4'h4:       return PAT_4;
      4'h5:       return PAT_5;
      4'h6:       return PAT_6;
      4'h7:       return PAT_7;
      4'h8:       return PAT_8;
      4'h9:       return PAT_9;
      CODE_MINUS: return PAT_MINUS;
      default:    return PAT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational seven-segment pattern to code lookup
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       hit
);

  always_comb begin
    code = CODE_BLANK;
    hit  = 1'b1;
    case (pattern)
      PAT_0:     code = 4'h0;
      PAT_1:     code = 4'h1;
      PAT_2:     code = 4'h2;
      PAT_3:     code = 4'h3;
      PAT_4:     code = 4'h4;
      PAT_5:     code = 4'h5;
      PAT_6:     code = 4'h6;
      PAT_7:     code = 4'h7;
      PAT_8:     code = 4'h8;
      PAT_9:     code = 4'h9;
      PAT_MINUS: code = CODE_MINUS;
      PAT_BLANK: code = CODE_BLANK;
      default:   hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounced capture of a multiplexed 8-digit seven-segment scan
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  dig_sel,
  output logic [31:0] digits,
  output logic [7:0]  dig_valid,
  output logic        frame_done,
  output logic        err,
  output logic [7:0]  err_pattern
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [6:0]  seg_r;
  logic [7:0]  sel_r;
  logic [14:0] last_pair;
  logic [7:0]  cnt, cnt_next;
  logic [7:0]  seen;
  state_t      state, state_next;
  logic        capture;
  logic        sel_ok;
  logic        changed;
  logic [3:0]  code;
  logic        hit;
  logic        unused_dp;

  // DP plays no part in decoding or stability, so it is never registered.
  assign unused_dp = seg_in[0];

  assign sel_ok  = (sel_r != 8'd0) && ((sel_r & (sel_r - 8'd1)) == 8'd0);
  assign changed = ({seg_r, sel_r} != last_pair);

  seg_pattern_decode u_decode (
    .pattern (seg_r),
    .code    (code),
    .hit     (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r     <= '0;
      sel_r     <= '0;
      last_pair <= '0;
      state     <= IDLE;
      cnt       <= '0;
    end else begin
      seg_r     <= seg_in[7:1];
      sel_r     <= dig_sel;
      last_pair <= {seg_r, sel_r};
      state     <= state_next;
      cnt       <= cnt_next;
    end
  end

  // Capture fires on the edge where the count would reach STABLE_CYCLES,
  // so the decoded value is visible one clock after the dwell completes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    if (!sel_ok) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = SETTLE;
          cnt_next   = 8'd1;
        end
        SETTLE: begin
          if (changed) begin
            cnt_next = 8'd1;
          end else if (cnt + 8'd1 >= STABLE_W) begin
            capture    = 1'b1;
            cnt_next   = STABLE_W;
            state_next = HELD;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
        HELD: begin
          if (changed) begin
            state_next = SETTLE;
            cnt_next   = 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 32'hFFFF_FFFF;
      dig_valid   <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_pattern <= '0;
    end else begin
      frame_done <= (seen == 8'hFF);
      err        <= capture && !hit;
      seen       <= ((seen == 8'hFF) ? 8'h00 : seen) | (capture ? sel_r : 8'h00);
      if (capture) begin
        if (hit) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_r[i]) digits[4*i +: 4] <= code;
          end
          dig_valid <= dig_valid | sel_r;
        end else begin
          dig_valid   <= dig_valid & ~sel_r;
          err_pattern <= {seg_r, 1'b0};
        end
      end
    end
  end

endmodule
